tdm_mux: RTL
============

Name: tdm_mux

Overview:
Parametrised, registered N-channel multiplexer with a time-division scan mode. It selects one WIDTH-bit channel out of CHANNELS packed inputs. The channel comes either from an external select (manual mode) or from an internal round-robin pointer that advances every DWELL cycles (scan mode). The output is registered and carries a valid/ready handshake with backpressure, so a serial consumer (display driver, UART framer) can drain samples.

Parameters:
- WIDTH, 4, bits per channel
- CHANNELS, 4, number of input channels (>=2)
- DWELL, 2, cycles per channel in scan mode (>=1)
- SEL_W, $clog2(CHANNELS), select/pointer width (derived; not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- d  in  WIDTH*CHANNELS  packed inputs; channel i at d[i*WIDTH +: WIDTH]
- mode  in  1  0 = manual, 1 = scan
- sel  in  SEL_W  channel select, used in manual mode only
- out_ready  in  1  consumer accepts y this cycle
- y  out  WIDTH  selected sample
- y_ch  out  SEL_W  channel index of y
- y_valid  out  1  y/y_ch hold a sample

Behaviour:
- Reset: synchronous only, sampled on the clk edge. Clears y=0, y_ch=0, y_valid=0, ptr=0, cnt=0 and the FSM to MANUAL. Reset overrides every other input, including mid-scan or mid-stall.
- Slot free: free = !y_valid || out_ready. A sample transfers when y_valid && out_ready.
- Load: when free and a load is due, the registers capture y=d[ch], y_ch=ch, y_valid=1. Latency is 1 cycle from input to y.
- Valid clear: if a transfer happens and no load occurs in the same cycle, y_valid goes to 0. A simultaneous transfer and load yields a back-to-back sample.
- Backpressure: while y_valid && !out_ready, y, y_ch and y_valid hold steady and the ptr/cnt state freezes.
- FSM state MANUAL (mode=0):
  - Loads every cycle the slot is free, with ch=sel.
  - A sel value >= CHANNELS is clamped to CHANNELS-1.
  - mode=1 moves to SCAN and sets ptr=0, cnt=0.
- FSM state SCAN (mode=1):
  - If cnt < DWELL-1, then cnt++.
  - If cnt == DWELL-1 and free: load with ch=ptr, then ptr = (ptr == CHANNELS-1) ? 0 : ptr+1 and cnt=0.
  - If cnt == DWELL-1 and not free: go to HOLD.
  - mode=0 returns to MANUAL.
- FSM state HOLD:
  - cnt stays at DWELL-1.
  - When free: load from ptr, advance ptr, cnt=0, return to SCAN.
  - mode=0 returns to MANUAL without loading; the current y is kept until transferred.
- Scan cadence: with out_ready=1, one sample every DWELL cycles. DWELL=1 gives one sample per cycle.
- Pointer wrap: ptr wraps CHANNELS-1 -> 0. This also holds when CHANNELS is not a power of 2.
- Mode change: takes effect at the next edge. A sample already held in y is never dropped or overwritten while stalled.
- Input sampling: d is sampled only on the load edge; changes on d between loads are ignored.

Optional Feature:
- Macro: TDM_MUX_MASK_EN.
- Defined:
  - Adds an input port ch_mask (CHANNELS bits).
  - Scan loads only enabled channels: ptr advances to the next set bit after the current one, with wrap.
  - If the mask is all zero, no loads occur; y drains normally and y_valid then stays 0.
  - In manual mode, a masked-off sel produces no load.
  - Mask changes take effect on the next pointer advance.
- Undefined: no ch_mask port; all channels are enabled.

Decomposition:
- Shared package/include tdm_mux_pkg holds:
  - FSM state encoding (MANUAL, SCAN, HOLD)
  - MODE_MANUAL/MODE_SCAN constants
  - the channel-slice helper function
- Sub-module tdm_mux_next_ch: combinational "next enabled channel after ptr, with wrap", plus an any-enabled flag. It is instantiated only under TDM_MUX_MASK_EN; otherwise ptr+1 with wrap is inline.

Test Plan:
Common setup: WIDTH=4, CHANNELS=4, DWELL=2, d={4'hD,4'hC,4'hB,4'hA} (ch0=A).
- Manual: mode=0, out_ready=1, sel=0,1,2,3 on consecutive cycles -> y=A,B,C,D one cycle later each, with y_ch=0..3 and y_valid=1 continuously.
- Scan with wrap: mode=1, out_ready=1 -> y_valid pulses every 2nd cycle; y=A,B,C,D,A; y_ch=0,1,2,3,0.
- Backpressure: in scan, hold out_ready=0 for 5 cycles from the B load -> y=B, y_ch=1, y_valid=1 stable. Release out_ready -> B transfers and C loads on that edge.
- Reset mid-scan: rst=1 for one cycle at ptr=2 -> next cycle y=0, y_ch=0, y_valid=0. With mode=1 still high, the first sample after reset is A.
- Mode switch: scan to mode=0 with sel=3 while the slot is free -> next cycle y=D, y_ch=3. Also sel=3 with CHANNELS=3 -> clamps to ch2.
- Mask (TDM_MUX_MASK_EN): ch_mask=4'b1010, scan -> y=B,D,B,D. Then ch_mask=0 -> y_valid falls after the last transfer and stays 0.

Source files
------------

// File: rtl/tdm_mux_pkg.sv
// Shared types and helpers for the tdm_mux block: FSM encoding, mode constants
// and the channel-slice offset helper.
package tdm_mux_pkg;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SCAN   = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // LSB position of channel ch inside the packed input vector.
  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/tdm_mux_next_ch.sv
// Finds the next enabled channel after ptr_i (with wrap) and flags whether any
// channel is enabled at all. Used only when TDM_MUX_MASK_EN is defined.
module tdm_mux_next_ch #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [SEL_W-1:0]    ptr_i,
  input  logic [CHANNELS-1:0] mask_i,
  output logic [SEL_W-1:0]    next_ch_o,
  output logic                any_en_o
);

  // Scan distances from farthest to nearest so the nearest enabled one wins;
  // with only ptr_i itself enabled the pointer stays put.
  always_comb begin
    next_ch_o = ptr_i;
    for (int k = CHANNELS - 1; k >= 1; k--) begin
      if (mask_i[(int'(ptr_i) + k) % CHANNELS]) begin
        next_ch_o = SEL_W'((int'(ptr_i) + k) % CHANNELS);
      end
    end
  end

  assign any_en_o = |mask_i;

endmodule

// File: rtl/tdm_mux.sv
// Registered N-channel mux with manual select and round-robin scan mode,
// valid/ready output. Optional channel mask enabled by TDM_MUX_MASK_EN.
module tdm_mux
  import tdm_mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 2,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH*CHANNELS-1:0] d,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      out_ready,
`ifdef TDM_MUX_MASK_EN
  input  logic [CHANNELS-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          y_ch,
  output logic                      y_valid
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [SEL_W-1:0]   y_ch_q, y_ch_d;
  logic               y_valid_q, y_valid_d;

  logic               free;
  logic               load_en;
  logic               adv;
  logic [SEL_W-1:0]   load_ch;
  logic [SEL_W-1:0]   sel_c;
  logic [SEL_W-1:0]   ptr_adv;
  logic               ptr_ok;
  logic               sel_ok;

  assign free  = !y_valid_q || out_ready;
  assign sel_c = (int'(sel) >= CHANNELS) ? SEL_W'(CHANNELS - 1) : sel;

`ifdef TDM_MUX_MASK_EN
  logic any_en;

  tdm_mux_next_ch #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_next_ch (
    .ptr_i     (ptr_q),
    .mask_i    (ch_mask),
    .next_ch_o (ptr_adv),
    .any_en_o  (any_en)
  );

  assign ptr_ok = any_en && ch_mask[ptr_q];
  assign sel_ok = ch_mask[sel_c];
`else
  assign ptr_adv = (ptr_q == SEL_W'(CHANNELS - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_ok  = 1'b1;
  assign sel_ok  = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    load_en = 1'b0;
    load_ch = ptr_q;
    adv     = 1'b0;

    case (state_q)
      ST_MANUAL: begin
        if (mode == MODE_SCAN) begin
          state_d = ST_SCAN;
          ptr_d   = '0;
          cnt_d   = '0;
        end else if (free && sel_ok) begin
          load_en = 1'b1;
          load_ch = sel_c;
        end
      end
      ST_SCAN: begin
        if (mode == MODE_MANUAL) begin
          state_d = ST_MANUAL;
          if (free && sel_ok) begin
            load_en = 1'b1;
            load_ch = sel_c;
          end
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!free) begin
          state_d = ST_HOLD;
        end else begin
          adv = 1'b1;
        end
      end
      ST_HOLD: begin
        // Leaving a stalled scan never loads; the held sample drains first.
        if (mode == MODE_MANUAL) begin
          state_d = ST_MANUAL;
        end else if (free) begin
          adv     = 1'b1;
          state_d = ST_SCAN;
        end
      end
      default: state_d = ST_MANUAL;
    endcase

    // A masked-off pointer is skipped without a load; the slot stays due.
    if (adv) begin
      ptr_d = ptr_adv;
      if (ptr_ok) begin
        load_en = 1'b1;
        load_ch = ptr_q;
        cnt_d   = '0;
      end
    end

    y_d       = y_q;
    y_ch_d    = y_ch_q;
    y_valid_d = y_valid_q;
    if (load_en) begin
      y_d       = d[ch_lsb(int'(load_ch), WIDTH) +: WIDTH];
      y_ch_d    = load_ch;
      y_valid_d = 1'b1;
    end else if (out_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_MANUAL;
      ptr_q     <= '0;
      cnt_q     <= '0;
      y_q       <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y       = y_q;
  assign y_ch    = y_ch_q;
  assign y_valid = y_valid_q;

endmodule
